// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response valid-ready bus between the core (master) and the data memory (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_adr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_adr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_adr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_ram.sv
// Word-wide RAM, synchronous byte-lane write, combinational read, one shared index.
// No reset: contents survive a responder reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, LATENCY wait states, then a response
// held until rsp_ready; req_ready is low from accept until the cycle after the handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [WORD_W-1:0] adr_q, adr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic              commit;
    logic              cur_wr;
    logic [WORD_W-1:0] cur_adr;
    logic [WORD_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic              addr_err;
    logic [AW-1:0]     idx;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With LATENCY==0 the commit happens on the accept edge, so use the live request.
    assign cur_wr    = (state_q == IDLE) ? bus.req_write : wr_q;
    assign cur_adr   = (state_q == IDLE) ? bus.req_adr   : adr_q;
    assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign cur_be    = (state_q == IDLE) ? bus.req_be    : be_q;

    assign commit = (accept && (LAT == 4'd0)) ||
                    ((state_q == WAIT) && (cnt_q <= 4'd1));

    assign addr_err = (cur_adr[1:0] != 2'b00) || (cur_adr[WORD_W-1:AW+2] != '0);
    assign idx      = cur_adr[AW+1:2];
    assign ram_we   = commit && cur_wr && !addr_err;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (cur_be),
        .idx_i   (idx),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = bus.req_write;
                    adr_d   = bus.req_adr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = addr_err;
            rsp_rdata_d = (!cur_wr && !addr_err) ? ram_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
